// File: rtl/salsa20_round_engine.sv
// Iterative Salsa20 core permutation: ROUNDS column/row rounds, ROUNDS_PER_CYCLE per clock.
// Define SALSA20_FEEDFORWARD_EN for the hash output (work + original state per word).

module salsa20_quarter_round (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  output logic [31:0] a_new,
  output logic [31:0] b_new,
  output logic [31:0] c_new,
  output logic [31:0] d_new
);

  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
    rotl = (x << n) | (x >> (32'd32 - n));
  endfunction

  logic [31:0] a_s;
  logic [31:0] b_s;
  logic [31:0] c_s;
  logic [31:0] d_s;

  // Each step consumes the word updated by the previous step, in fixed Salsa20 order.
  always_comb begin
    b_s = b ^ rotl(a + d, 32'd7);
    c_s = c ^ rotl(b_s + a, 32'd9);
    d_s = d ^ rotl(c_s + b_s, 32'd13);
    a_s = a ^ rotl(d_s + c_s, 32'd18);
  end

  assign a_new = a_s;
  assign b_new = b_s;
  assign c_new = c_s;
  assign d_new = d_s;

endmodule

module salsa20_round #(
  parameter bit ROW = 1'b0
) (
  input  logic [511:0] state,
  output logic [511:0] result
);

  localparam int COL_IDX [16] = '{0, 4, 8, 12, 5, 9, 13, 1, 10, 14, 2, 6, 15, 3, 7, 11};
  localparam int ROW_IDX [16] = '{0, 1, 2, 3, 5, 6, 7, 4, 10, 11, 8, 9, 15, 12, 13, 14};

  logic [31:0] w_s [16];
  logic [31:0] r_s [16];

  for (genvar i = 0; i < 16; i++) begin : g_words
    assign w_s[i] = state[32*i +: 32];
    assign result[32*i +: 32] = r_s[i];
  end

  // The four quarter-rounds of one round touch disjoint words, so they run in parallel.
  for (genvar q = 0; q < 4; q++) begin : g_qr
    localparam int IA = ROW ? ROW_IDX[4*q]     : COL_IDX[4*q];
    localparam int IB = ROW ? ROW_IDX[4*q + 1] : COL_IDX[4*q + 1];
    localparam int IC = ROW ? ROW_IDX[4*q + 2] : COL_IDX[4*q + 2];
    localparam int ID = ROW ? ROW_IDX[4*q + 3] : COL_IDX[4*q + 3];

    salsa20_quarter_round u_qr (
      .a     (w_s[IA]),
      .b     (w_s[IB]),
      .c     (w_s[IC]),
      .d     (w_s[ID]),
      .a_new (r_s[IA]),
      .b_new (r_s[IB]),
      .c_new (r_s[IC]),
      .d_new (r_s[ID])
    );
  end

endmodule

module salsa20_round_engine #(
  parameter int ROUNDS           = 20,
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_data,
  output logic         busy
);

  localparam int CNT_W = (ROUNDS < 2) ? 1 : $clog2(ROUNDS + 1);

  if (ROUNDS < 1) begin : g_err_rounds
    $error("salsa20_round_engine: ROUNDS must be >= 1");
  end
  if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2) begin : g_err_rpc
    $error("salsa20_round_engine: ROUNDS_PER_CYCLE must be 1 or 2");
  end else if ((ROUNDS % ROUNDS_PER_CYCLE) != 0) begin : g_err_mult
    $error("salsa20_round_engine: ROUNDS must be a multiple of ROUNDS_PER_CYCLE");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [511:0]       work_r;
  logic [511:0]       out_data_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic               busy_r;

  logic [511:0]       col_s;
  logic [511:0]       row_in_s;
  logic [511:0]       row_s;
  logic [511:0]       next_work_s;
  logic [511:0]       result_s;
  logic [CNT_W-1:0]   cnt_next_s;
  logic               last_s;

  salsa20_round #(.ROW(1'b0)) u_col (.state(work_r),   .result(col_s));
  salsa20_round #(.ROW(1'b1)) u_row (.state(row_in_s), .result(row_s));

  if (ROUNDS_PER_CYCLE == 2) begin : g_double
    assign row_in_s    = col_s;
    assign next_work_s = row_s;
  end else begin : g_single
    assign row_in_s    = work_r;
    // Counter parity equals global round parity: even = column, odd = row.
    assign next_work_s = cnt_r[0] ? row_s : col_s;
  end

  assign cnt_next_s = cnt_r + CNT_W'(ROUNDS_PER_CYCLE);
  assign last_s     = (cnt_next_s == CNT_W'(ROUNDS));

`ifdef SALSA20_FEEDFORWARD_EN
  logic [511:0] orig_r;

  function automatic logic [511:0] add_words(input logic [511:0] x, input logic [511:0] y);
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
    end
    return r;
  endfunction

  assign result_s = add_words(next_work_s, orig_r);

  // Original input kept for the per-word feed-forward addition.
  always_ff @(posedge clk) begin
    if (rst) begin
      orig_r <= '0;
    end else if (state_r == ST_IDLE && in_valid && in_ready_r) begin
      orig_r <= in_data;
    end
  end
`else
  assign result_s = next_work_s;
`endif

  // Control FSM; the result is captured on the final round edge so outputs stay registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      work_r      <= '0;
      out_data_r  <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid && in_ready_r) begin
            work_r     <= in_data;
            cnt_r      <= '0;
            state_r    <= ST_RUN;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        ST_RUN: begin
          work_r <= next_work_s;
          cnt_r  <= cnt_next_s;
          if (last_s) begin
            state_r     <= ST_DONE;
            out_data_r  <= result_s;
            out_valid_r <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          cnt_r       <= '0;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_salsa20_round_engine.sv
// Bench for salsa20_round_engine: four configurations driven with directed vectors; a negedge
// monitor pops the expected result queue on every rising out_valid and checks data and latency.
`timescale 1ns/1ps
module tb_salsa20_round_engine;

  localparam int NDUT = 4;
  localparam int LAT [4] = '{20, 1, 1, 2};
`ifdef SALSA20_FEEDFORWARD_EN
  localparam bit FF = 1'b1;
`else
  localparam bit FF = 1'b0;
`endif
  localparam int COL_IDX [16] = '{0, 4, 8, 12, 5, 9, 13, 1, 10, 14, 2, 6, 15, 3, 7, 11};
  localparam int ROW_IDX [16] = '{0, 1, 2, 3, 5, 6, 7, 4, 10, 11, 8, 9, 15, 12, 13, 14};

  typedef struct {
    logic [511:0] data;
    int           acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid  [4];
  logic         in_ready  [4];
  logic [511:0] in_data   [4];
  logic         out_valid [4];
  logic         out_ready [4];
  logic [511:0] out_data  [4];
  logic         busy      [4];
  logic         prev_v    [4];

  exp_t exp_q [4][$];
  exp_t mon_e;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  salsa20_round_engine #(.ROUNDS(20), .ROUNDS_PER_CYCLE(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0]));
  salsa20_round_engine #(.ROUNDS(1), .ROUNDS_PER_CYCLE(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1]));
  salsa20_round_engine #(.ROUNDS(2), .ROUNDS_PER_CYCLE(2)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]), .busy(busy[2]));
  salsa20_round_engine #(.ROUNDS(2), .ROUNDS_PER_CYCLE(1)) dut_d (
    .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]), .in_data(in_data[3]),
    .out_valid(out_valid[3]), .out_ready(out_ready[3]), .out_data(out_data[3]), .busy(busy[3]));

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [511:0] salsa_model(input logic [511:0] s, input int rounds, input bit ff);
    logic [31:0]  x [16];
    logic [511:0] r;
    int a, b, c, d;
    for (int i = 0; i < 16; i++) x[i] = s[32*i +: 32];
    for (int n = 0; n < rounds; n++) begin
      for (int q = 0; q < 4; q++) begin
        if (n % 2 == 0) begin
          a = COL_IDX[4*q]; b = COL_IDX[4*q+1]; c = COL_IDX[4*q+2]; d = COL_IDX[4*q+3];
        end else begin
          a = ROW_IDX[4*q]; b = ROW_IDX[4*q+1]; c = ROW_IDX[4*q+2]; d = ROW_IDX[4*q+3];
        end
        x[b] = x[b] ^ rl(x[a] + x[d], 7);
        x[c] = x[c] ^ rl(x[b] + x[a], 9);
        x[d] = x[d] ^ rl(x[c] + x[b], 13);
        x[a] = x[a] ^ rl(x[d] + x[c], 18);
      end
    end
    for (int i = 0; i < 16; i++) r[32*i +: 32] = ff ? x[i] + s[32*i +: 32] : x[i];
    return r;
  endfunction

  function automatic logic [511:0] rand_state();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic send(input int k, input logic [511:0] d, input logic [511:0] e);
    int guard;
    guard = 0;
    @(negedge clk);
    in_valid[k] = 1'b1;
    in_data[k]  = d;
    while (in_ready[k] !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      n_checks++;
      $display("FAIL accept_timeout dut%0d: in_ready=%b required 1", k, in_ready[k]);
    end else begin
      exp_q[k].push_back('{e, cyc + 1});
    end
    @(posedge clk);
    #1 in_valid[k] = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size() != 0 ||
            (busy[0] | busy[1] | busy[2] | busy[3]) !== 1'b0) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) begin
      n_checks++;
      $display("FAIL drain_timeout: pending=%0d required 0",
               exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size());
    end
  endtask

  // Scoreboard monitor: each rising out_valid must match the oldest expectation and latency.
  always @(negedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      if (rst === 1'b0 && out_valid[k] === 1'b1 && prev_v[k] !== 1'b1) begin
        if (exp_q[k].size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_output dut%0d: got out_valid=1 required no output", k);
        end else begin
          mon_e = exp_q[k].pop_front();
          chk($sformatf("data_dut%0d", k), out_data[k], mon_e.data);
          chk($sformatf("latency_dut%0d", k), 512'(cyc - mon_e.acc), 512'(LAT[k]));
        end
      end
      prev_v[k] <= out_valid[k];
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [511:0] s;
    logic [511:0] e;
    int guard;
    rst = 1'b1;
    for (int k = 0; k < NDUT; k++) begin
      in_valid[k]  = 1'b0;
      in_data[k]   = '0;
      out_ready[k] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 512'(in_ready[0]), 512'd1);
    chk("reset_out_valid", 512'(out_valid[0]), 512'd0);
    chk("reset_busy", 512'(busy[0]), 512'd0);
    chk("reset_out_data", out_data[0], 512'd0);

    // Zero state stays zero in both builds.
    send(0, 512'd0, 512'd0);

    // Single column round on word0 = 1.
    s = '0;
    s[31:0] = 32'h0000_0001;
    e = '0;
    e[31:0]    = FF ? 32'h0800_8146 : 32'h0800_8145;
    e[159:128] = 32'h0000_0080;
    e[287:256] = 32'h0001_0200;
    e[415:384] = 32'h2050_0000;
    send(1, s, e);

    for (int i = 0; i < 5; i++) begin
      s = rand_state();
      send(0, s, salsa_model(s, 20, FF));
    end

    // Double round per clock against two single rounds.
    for (int i = 0; i < 20; i++) begin
      s = rand_state();
      e = salsa_model(s, 2, FF);
      send(2, s, e);
      send(3, s, e);
    end
    drain();

    // Backpressure: DONE held, data stable, new input refused.
    s = rand_state();
    e = salsa_model(s, 20, FF);
    out_ready[0] = 1'b0;
    send(0, s, e);
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (out_valid[0] !== 1'b1 && guard < 100);
    in_valid[0] = 1'b1;
    in_data[0]  = ~s;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 512'(out_valid[0]), 512'd1);
      chk("bp_out_data", out_data[0], e);
      chk("bp_in_ready", 512'(in_ready[0]), 512'd0);
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    drain();

    // Reset at cnt=7 discards the block; rst beats a same-edge in_valid.
    s = rand_state();
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_data[0]  = s;
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("run_busy", 512'(busy[0]), 512'd1);
    chk("run_in_ready", 512'(in_ready[0]), 512'd0);
    rst = 1'b1;
    in_valid[0] = 1'b1;
    in_data[0]  = ~s;
    @(posedge clk);
    #1 rst = 1'b0;
    in_valid[0] = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 512'(in_ready[0]), 512'd1);
    chk("rst_out_valid", 512'(out_valid[0]), 512'd0);
    chk("rst_out_data", out_data[0], 512'd0);
    chk("rst_busy", 512'(busy[0]), 512'd0);
    repeat (25) @(negedge clk);
    chk("rst_no_accept", 512'(busy[0]), 512'd0);

    s = rand_state();
    send(0, s, salsa_model(s, 20, FF));
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
